mat_operand_loader: RTL

//  Upstream feeder for the 2x2 matrix multiplier. Accepts a byte-serial element stream over valid/ready
//  and assembles matrix A (4 elements), then matrix B (4 elements). Presents each completed pair as

---
 rtl/mat_pkg.sv | 19 +
 rtl/mat_elem_packer.sv | 35 +++
 rtl/mat_operand_loader.sv | 112 +++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared widths, loader FSM states and row-major slot mapping for the 2x2 operand loader
package mat_pkg;

  localparam int ELEM_W_DEFAULT = 8;
  localparam int DIM            = 2;
  localparam int N_ELEM         = DIM * DIM;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  // Row-major element index -> packed slot; slot 3 is the MSB element (m00).
  function automatic logic [1:0] pack_rm(input logic [1:0] idx);
    return 2'(N_ELEM - 1) - idx;
  endfunction

endpackage

// File: rtl/mat_elem_packer.sv
// rtl/mat_elem_packer.sv - 4-element matrix register written by arrival index, packed row-major
module mat_elem_packer
  import mat_pkg::*;
#(
  parameter int ELEM_W   = ELEM_W_DEFAULT,
  parameter bit COLMAJOR = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [1:0]            idx,
  input  logic [ELEM_W-1:0]     din,
  output logic [4*ELEM_W-1:0]   mat
);

  logic [4*ELEM_W-1:0] mat_q;
  logic [1:0]          pos;
  logic [1:0]          slot;

  // Column-major arrival swaps row/col bits of the index to get the row-major position.
  assign pos  = COLMAJOR ? {idx[0], idx[1]} : idx;
  assign slot = pack_rm(pos);

  // mat shows the pending write merged in, so the last element is usable on its own edge.
  always_comb begin
    mat = mat_q;
    if (we) mat[slot*ELEM_W +: ELEM_W] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mat_q <= '0;
    else        mat_q <= mat;
  end

endmodule

// File: rtl/mat_operand_loader.sv
// rtl/mat_operand_loader.sv - byte-serial A/B assembler with staging slot; MAT_LOADER_COLMAJOR_B_EN selects column-major B arrival
module mat_operand_loader
  import mat_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ELEM_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_sof,
  output logic                in_ready,
  output logic [4*ELEM_W-1:0] op_a,
  output logic [4*ELEM_W-1:0] op_b,
  output logic                op_valid,
  input  logic                op_ready,
  output logic                resync_err,
  input  logic                err_clr
);

`ifdef MAT_LOADER_COLMAJOR_B_EN
  localparam bit B_COLMAJOR = 1'b1;
`else
  localparam bit B_COLMAJOR = 1'b0;
`endif

  state_t              state, state_nx;
  logic [1:0]          idx, idx_nx;
  logic                in_ready_q;
  logic                accept, resync, last_a, last_b, slot_free;
  logic                a_we, b_we;
  logic [1:0]          a_idx;
  logic [4*ELEM_W-1:0] a_mat, b_mat, stage_a, stage_b;

  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign resync    = accept && in_sof && !(state == LOAD_A && idx == 2'd0);
  assign last_a    = accept && !resync && state == LOAD_A && idx == 2'd3;
  assign last_b    = accept && !resync && state == LOAD_B && idx == 2'd3;
  assign slot_free = !op_valid || op_ready;

  // A resync restarts the pair with the sof byte written as a00.
  assign a_we  = accept && (state == LOAD_A || resync);
  assign a_idx = resync ? 2'd0 : idx;
  assign b_we  = accept && state == LOAD_B && !resync;

  mat_elem_packer #(.ELEM_W(ELEM_W), .COLMAJOR(1'b0)) u_pack_a (
    .clk(clk), .rst_n(rst_n), .we(a_we), .idx(a_idx), .din(in_data), .mat(a_mat)
  );

  mat_elem_packer #(.ELEM_W(ELEM_W), .COLMAJOR(B_COLMAJOR)) u_pack_b (
    .clk(clk), .rst_n(rst_n), .we(b_we), .idx(idx), .din(in_data), .mat(b_mat)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (resync) begin
      state_nx = LOAD_A;
      idx_nx   = 2'd1;
    end else if (accept) begin
      idx_nx = idx + 2'd1;
      if (last_a) state_nx = LOAD_B;
      if (last_b) state_nx = slot_free ? LOAD_A : FULL;
    end else if (state == FULL && op_ready) begin
      state_nx = LOAD_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD_A;
      idx        <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      in_ready_q <= (state_nx != FULL);
    end
  end

  // FULL implies op_valid, so an op_ready there always drains staging into the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      stage_a  <= '0;
      stage_b  <= '0;
    end else if (state == FULL && op_ready) begin
      op_a     <= stage_a;
      op_b     <= stage_b;
      op_valid <= 1'b1;
    end else if (last_b && slot_free) begin
      op_a     <= a_mat;
      op_b     <= b_mat;
      op_valid <= 1'b1;
    end else if (last_b) begin
      stage_a  <= a_mat;
      stage_b  <= b_mat;
    end else if (op_valid && op_ready) begin
      op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       resync_err <= 1'b0;
    else if (resync)  resync_err <= 1'b1;
    else if (err_clr) resync_err <= 1'b0;
  end

endmodule
